// File: rtl/alu_packet_engine.sv
// alu_packet_engine
//   Byte-stream command processor sitting between a UART receiver and transmitter.
//   Parses length-framed packets {opcode, rsvd, len_lo, len_hi, payload}.
//   It answers with one of three things:
//     - the echoed payload (0xEC),
//     - an N-operand ADD (0xA0) or MUL (0xA1) result, DATA_W/8 bytes sent LSB first,
//     - a single ERR_BYTE when the packet is rejected.
//   LEN = {len_hi, len_lo} counts the whole packet, header included.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   in_data_i    RX byte
//   in_valid_i   RX byte valid
//   in_ready_o   RX byte accepted when valid & ready
//   out_data_o   TX byte
//   out_valid_o  TX byte valid (held with out_data_o until out_ready_i)
//   out_ready_i  TX sink ready
//   busy_o       high whenever the engine is not idle
//   err_o        one-cycle pulse when a packet is rejected
//   pkt_done_o   one-cycle pulse on the last response byte accept (or echo with LEN==4)
module alu_packet_engine #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_LEN  = 256,
  parameter bit          MUL_EN   = 1'b1,
  parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       busy_o,
  output logic       err_o,
  output logic       pkt_done_o
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [3:0] {
    IDLE, RSVD, LEN_LO, LEN_HI, ECHO, OPERAND, RESULT, DRAIN, ERR_TX
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [7:0]        lenLo_q, lenLo_d;
  logic [15:0]       remain_q, remain_d;
  logic [IDXW-1:0]   byteIdx_q, byteIdx_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              firstWord_q, firstWord_d;
  logic              err_q, err_d;

  logic [15:0]       lenFull;
  logic [15:0]       payloadLen;
  logic              isEcho, isAdd, isMul, isAlu;
  logic              aluLenOk, lenErr, pktErr;
  logic [DATA_W-1:0] wordNext;
  logic [DATA_W-1:0] aluResult;
  logic [7:0]        resByte;

  // Header decode uses the length high byte straight off the bus so the branch
  // out of LEN_HI happens on the same edge that accepts it.
  always_comb begin
    lenFull    = {in_data_i, lenLo_q};
    payloadLen = lenFull - 16'd4;
    isEcho     = (opcode_q == 8'hEC);
    isAdd      = (opcode_q == 8'hA0);
    isMul      = (opcode_q == 8'hA1) && MUL_EN;
    isAlu      = isAdd || isMul;
    aluLenOk   = (lenFull > 16'd4) && ((payloadLen % 16'(NBYTES)) == 16'd0);
    lenErr     = (lenFull < 16'd4) || (lenFull > 16'(MAX_LEN));
    pktErr     = lenErr || !(isEcho || isAlu) || (isAlu && !aluLenOk);
  end

  // Little-endian word assembly: the incoming byte drops into the slot picked by
  // byteIdx_q; the completed word is folded into acc on the same edge.
  always_comb begin
    wordNext = word_q;
    wordNext[{byteIdx_q, 3'b000} +: 8] = in_data_i;
    aluResult = isMul ? (acc_q * wordNext) : (acc_q + wordNext);
    resByte   = acc_q[{byteIdx_q, 3'b000} +: 8];
  end

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    lenLo_d     = lenLo_q;
    remain_d    = remain_q;
    byteIdx_d   = byteIdx_q;
    word_d      = word_q;
    acc_d       = acc_q;
    firstWord_d = firstWord_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = 8'h00;
    pkt_done_o  = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          opcode_d = in_data_i;
          state_d  = RSVD;
        end
      end
      RSVD: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_d = LEN_LO;
      end
      LEN_LO: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          lenLo_d = in_data_i;
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          remain_d    = payloadLen;
          byteIdx_d   = '0;
          firstWord_d = 1'b1;
          if (pktErr) begin
            state_d = (lenFull > 16'd4) ? DRAIN : ERR_TX;
          end else if (isEcho) begin
            if (lenFull == 16'd4) begin
              pkt_done_o = 1'b1;
              state_d    = IDLE;
            end else begin
              state_d = ECHO;
            end
          end else begin
            state_d = OPERAND;
          end
        end
      end
      ECHO: begin
        out_data_o  = in_data_i;
        out_valid_o = in_valid_i;
        in_ready_o  = out_ready_i;
        if (in_valid_i && out_ready_i) begin
          remain_d = remain_q - 16'd1;
          if (remain_q == 16'd1) begin
            pkt_done_o = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      OPERAND: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          word_d   = wordNext;
          remain_d = remain_q - 16'd1;
          if (byteIdx_q == LAST_IDX) begin
            byteIdx_d   = '0;
            acc_d       = firstWord_q ? wordNext : aluResult;
            firstWord_d = 1'b0;
          end else begin
            byteIdx_d = byteIdx_q + 1'b1;
          end
          if (remain_q == 16'd1) state_d = RESULT;
        end
      end
      RESULT: begin
        out_valid_o = 1'b1;
        out_data_o  = resByte;
        if (out_ready_i) begin
          if (byteIdx_q == LAST_IDX) begin
            byteIdx_d  = '0;
            pkt_done_o = 1'b1;
            state_d    = IDLE;
          end else begin
            byteIdx_d = byteIdx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          remain_d = remain_q - 16'd1;
          if (remain_q == 16'd1) state_d = ERR_TX;
        end
      end
      ERR_TX: begin
        out_valid_o = 1'b1;
        out_data_o  = ERR_BYTE;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // err_o is registered so it pulses in the first cycle spent in ERR_TX.
  assign err_d  = (state_d == ERR_TX) && (state_q != ERR_TX);
  assign err_o  = err_q;
  assign busy_o = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      opcode_q    <= 8'h00;
      lenLo_q     <= 8'h00;
      remain_q    <= 16'd0;
      byteIdx_q   <= '0;
      word_q      <= '0;
      acc_q       <= '0;
      firstWord_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      lenLo_q     <= lenLo_d;
      remain_q    <= remain_d;
      byteIdx_q   <= byteIdx_d;
      word_q      <= word_d;
      acc_q       <= acc_d;
      firstWord_q <= firstWord_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_packet_engine.sv
// tb_alu_packet_engine
//   Directed packets with hand-computed responses for alu_packet_engine, followed by
//   a batch of random ADD/MUL packets checked against a small arithmetic model.
//   A second instance built with MUL_EN=0 covers the disabled-MUL rejection.
module tb_alu_packet_engine;

  logic       clk = 1'b0;
  logic       rstN;
  logic [7:0] inData, outData;
  logic       inValid, inReady, outValid, outReady;
  logic       busy, err, pktDone;

  logic [7:0] inData2, outData2;
  logic       inValid2, inReady2, outValid2, outReady2;
  logic       busy2, err2, pktDone2;

  int passCount  = 0;
  int checkCount = 0;
  int errCount   = 0;
  int doneCount  = 0;
  int errCount2  = 0;

  logic [7:0] txQ[$];
  logic [7:0] expQ[$];
  logic [7:0] rxQ[$];

  always #5 clk = ~clk;

  alu_packet_engine #(.DATA_W(32), .MAX_LEN(256), .MUL_EN(1'b1), .ERR_BYTE(8'hEE)) dut (
    .clk_i(clk), .rst_ni(rstN),
    .in_data_i(inData), .in_valid_i(inValid), .in_ready_o(inReady),
    .out_data_o(outData), .out_valid_o(outValid), .out_ready_i(outReady),
    .busy_o(busy), .err_o(err), .pkt_done_o(pktDone)
  );

  alu_packet_engine #(.DATA_W(32), .MAX_LEN(256), .MUL_EN(1'b0), .ERR_BYTE(8'hEE)) dutNoMul (
    .clk_i(clk), .rst_ni(rstN),
    .in_data_i(inData2), .in_valid_i(inValid2), .in_ready_o(inReady2),
    .out_data_o(outData2), .out_valid_o(outValid2), .out_ready_i(outReady2),
    .busy_o(busy2), .err_o(err2), .pkt_done_o(pktDone2)
  );

  // Pulse counters, sampled mid-low-phase once all inputs have settled.
  always begin
    @(negedge clk);
    #2;
    if (err === 1'b1)     errCount++;
    if (pktDone === 1'b1) doneCount++;
    if (err2 === 1'b1)    errCount2++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Drives txQ into the main DUT one byte at a time, holding each until accepted.
  task automatic applyStimulus();
    int guard;
    for (int i = 0; i < txQ.size(); i++) begin
      @(negedge clk);
      inValid = 1'b1;
      inData  = txQ[i];
      #1;
      guard = 0;
      while (!inReady && guard < 1000) begin
        @(negedge clk);
        #1;
        guard++;
      end
      if (guard >= 1000) begin
        checkOutput("sendTimeout", 64'(guard), 64'(0));
        break;
      end
    end
    @(negedge clk);
    inValid = 1'b0;
    inData  = 8'h00;
  endtask

  // Collects n response bytes with random sink stalls and checks hold-while-stalled.
  task automatic collectBytes(input int n, input int stallPct);
    int cyc;
    logic prevStall;
    logic [7:0] prevData;
    cyc = 0;
    prevStall = 1'b0;
    prevData = 8'h00;
    rxQ.delete();
    while (rxQ.size() < n && cyc < 3000) begin
      @(negedge clk);
      outReady = ($urandom_range(99) >= stallPct);
      #1;
      if (prevStall) begin
        checkOutput("stallValid", 64'(outValid), 64'(1));
        checkOutput("stallData", 64'(outData), 64'(prevData));
      end
      prevStall = outValid && !outReady;
      prevData  = outData;
      if (outValid && outReady) rxQ.push_back(outData);
      cyc++;
    end
    if (rxQ.size() < n) checkOutput("recvTimeout", 64'(rxQ.size()), 64'(n));
    @(negedge clk);
    outReady = 1'b1;
  endtask

  task automatic runPacket(input string tag, input int expErr, input int expDone, input int stallPct);
    int e0, d0, extra;
    e0 = errCount;
    d0 = doneCount;
    extra = 0;
    fork
      applyStimulus();
      collectBytes(expQ.size(), stallPct);
    join
    repeat (4) begin
      @(negedge clk);
      #1;
      if (outValid) extra++;
    end
    checkOutput({tag, ".len"}, 64'(rxQ.size()), 64'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++)
      checkOutput($sformatf("%s.byte%0d", tag, i), 64'(rxQ[i]), 64'(expQ[i]));
    checkOutput({tag, ".err"}, 64'(errCount - e0), 64'(expErr));
    checkOutput({tag, ".done"}, 64'(doneCount - d0), 64'(expDone));
    checkOutput({tag, ".extra"}, 64'(extra), 64'(0));
    checkOutput({tag, ".idle"}, 64'(busy), 64'(0));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".inReady"}, 64'(inReady), 64'(1));
    checkOutput({tag, ".outValid"}, 64'(outValid), 64'(0));
    checkOutput({tag, ".outData"}, 64'(outData), 64'(0));
    checkOutput({tag, ".busy"}, 64'(busy), 64'(0));
    checkOutput({tag, ".err"}, 64'(err), 64'(0));
    checkOutput({tag, ".pktDone"}, 64'(pktDone), 64'(0));
  endtask

  initial begin
    logic [7:0] rx2[$];
    logic [31:0] acc, w;
    logic opMul;
    int nw, len;

    rstN = 1'b0; inValid = 1'b0; inData = 8'h00; outReady = 1'b1;
    inValid2 = 1'b0; inData2 = 8'h00; outReady2 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rstN = 1'b1;

    txQ = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h42, 8'h69, 8'h42, 8'h69};
    expQ = '{8'h42, 8'h69, 8'h42, 8'h69};
    runPacket("echo", 0, 1, 0);

    txQ = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    expQ = '{8'h00, 8'h00, 8'h00, 8'h00};
    runPacket("addWrap", 0, 1, 0);

    txQ = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    expQ = '{8'h0F, 8'h00, 8'h00, 8'h00};
    runPacket("mul", 0, 1, 0);

    // Same MUL packet into the MUL-disabled instance: drained, then a single EE.
    for (int i = 0; i < txQ.size(); i++) begin
      @(negedge clk);
      inValid2 = 1'b1;
      inData2  = txQ[i];
      #1;
      checkOutput($sformatf("mulOff.ready%0d", i), 64'(inReady2), 64'(1));
    end
    @(negedge clk);
    inValid2 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (outValid2 && outReady2) rx2.push_back(outData2);
      @(negedge clk);
    end
    checkOutput("mulOff.len", 64'(rx2.size()), 64'(1));
    if (rx2.size() > 0) checkOutput("mulOff.byte", 64'(rx2[0]), 64'(8'hEE));
    checkOutput("mulOff.err", 64'(errCount2), 64'(1));
    checkOutput("mulOff.done", 64'(pktDone2), 64'(0));
    checkOutput("mulOff.idle", 64'(busy2), 64'(0));

    txQ = '{8'hA0, 8'h00, 8'h0A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    expQ = '{8'hEE};
    runPacket("badLen", 1, 0, 0);

    txQ = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'hAA, 8'h55};
    expQ = '{8'hAA, 8'h55};
    runPacket("echoAfterErr", 0, 1, 0);

    txQ = '{8'hEC, 8'h00, 8'h04, 8'h00};
    expQ = '{};
    runPacket("echoLen4", 0, 1, 0);

    txQ = '{8'hA0, 8'h00, 8'h02, 8'h00};
    expQ = '{8'hEE};
    runPacket("lenShort", 1, 0, 0);

    txQ = '{8'hA1, 8'h00, 8'h04, 8'h00};
    expQ = '{8'hEE};
    runPacket("mulNoOperand", 1, 0, 0);

    txQ = '{8'h5A, 8'h00, 8'h05, 8'h00, 8'h33};
    expQ = '{8'hEE};
    runPacket("badOpcode", 1, 0, 0);

    txQ = '{8'hEC, 8'h00, 8'h04, 8'h01};
    for (int i = 0; i < 256; i++) txQ.push_back(8'(i));
    expQ = '{8'hEE};
    runPacket("lenOverMax", 1, 0, 0);

    txQ = '{8'hEC, 8'h00, 8'h00, 8'h01};
    expQ = '{};
    for (int i = 0; i < 252; i++) begin
      txQ.push_back(8'(i * 3));
      expQ.push_back(8'(i * 3));
    end
    runPacket("echoMaxLen", 0, 1, 0);

    // 0x11223344 + 0x01010101 + 0x10000000 = 0x22233445
    txQ = '{8'hA0, 8'h00, 8'h10, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
            8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h10};
    expQ = '{8'h45, 8'h34, 8'h23, 8'h22};
    runPacket("addStall", 0, 1, 30);

    txQ = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03};
    expQ = '{8'h01, 8'h02, 8'h03};
    runPacket("echoStall", 0, 1, 30);

    // Reset in the middle of an ADD operand.
    txQ = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01};
    applyStimulus();
    checkOutput("midPkt.busy", 64'(busy), 64'(1));
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkResetOutputs("midReset");
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;

    txQ = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
    expQ = '{8'h05, 8'h00, 8'h00, 8'h00};
    runPacket("afterReset", 0, 1, 0);

    for (int r = 0; r < 100; r++) begin
      opMul = 1'($urandom_range(1));
      nw    = int'($urandom_range(4, 1));
      len   = 4 + 4 * nw;
      txQ   = '{(opMul ? 8'hA1 : 8'hA0), 8'h00, 8'(len), 8'h00};
      acc   = 32'd0;
      for (int k = 0; k < nw; k++) begin
        w = $urandom;
        for (int b = 0; b < 4; b++) txQ.push_back(w[8*b +: 8]);
        if (k == 0) acc = w;
        else if (opMul) acc = acc * w;
        else acc = acc + w;
      end
      expQ = '{acc[7:0], acc[15:8], acc[23:16], acc[31:24]};
      runPacket($sformatf("rnd%0d", r), 0, 1, (r % 3 == 0) ? 30 : 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
